pulse_divider_ctrl: RTL
=======================

# pulse_divider_ctrl

Sequencing controller for the pulse divider's `counter16` datapath. It holds the divide configuration and drives the counter's target, enable and reset from a state machine. It emits a fixed-width output pulse each time the counter completes, then re-arms for a programmed number of bursts or runs continuously. It is the block firmware and front-panel logic talk to; `counter16` only counts.

## Interface
- `CNT_WIDTH`, default 16: width of ratio, burst and remaining counters; must match `counter16`.
- `PW_WIDTH`, default 8: width of the output-pulse-width field.

- `pulse_clock`  in  1  system clock; all logic on rising edge.
- `ctrl_reset`  in  1  reset, synchronous, active-high; highest priority.
- `cfg_load`  in  1  one-cycle strobe; captures `cfg_*` in IDLE or DONE only, ignored elsewhere.
- `cfg_ratio`  in  CNT_WIDTH  divide target; 0 is invalid.
- `cfg_bursts`  in  CNT_WIDTH  output pulses per run; 0 = continuous.
- `cfg_width`  in  PW_WIDTH  output pulse width in cycles; 0 treated as 1.
- `start`  in  1  one-cycle strobe; honoured in IDLE or DONE only.
- `abort`  in  1  forces IDLE from any state; priority over `start`/`cfg_load`.
- `cnt_completed`  in  1  latched completion from `counter16`, synchronous to `pulse_clock`.
- `cnt_target`  out  CNT_WIDTH  registered ratio; reset 16'd1.
- `cnt_enable`  out  1  counter enable; reset 0.
- `cnt_reset`  out  1  counter clear; reset 0.
- `pulse_out`  out  1  divided output pulse; reset 0.
- `busy`  out  1  high in CLEAR/COUNT/FIRE; reset 0.
- `done`  out  1  high in DONE; reset 0.
- `burst_remaining`  out  CNT_WIDTH  pulses left in current run; reset 0.
- `cfg_error`  out  1  sticky flag, set by a load with ratio 0, cleared by a valid load; reset 0.

## Operation
- Config registers reset to ratio 1, bursts 1, width 1. `cnt_target` mirrors the ratio register.
- States: IDLE, CLEAR, COUNT, FIRE, DONE. All outputs are Moore-decoded from registered state.
- IDLE: all strobes low. `start` → CLEAR, loads `burst_remaining` ← bursts register.
- CLEAR (1 cycle): `cnt_reset`=1, `cnt_enable`=0 → COUNT.
- COUNT: `cnt_enable`=1. `cnt_completed` is blanked on the first COUNT cycle after entry to mask a stale latch. From the second cycle on, `cnt_completed`=1 → FIRE.
- FIRE: `pulse_out`=1, `cnt_reset`=1, `cnt_enable`=0 for max(width,1) cycles. On entry, `burst_remaining` decrements if nonzero and mode is not continuous.
- End of FIRE: continuous mode → COUNT. Otherwise, `burst_remaining`=0 → DONE, else → COUNT.
- DONE: `done`=1. `start` reruns with the current config; `cfg_load` alone → IDLE.
- `abort`: → IDLE next cycle, with `cnt_reset`=1 for that one IDLE cycle; `burst_remaining` ← 0.
- `cfg_load` with ratio 0: registers unchanged, `cfg_error`=1. A `start` on the same cycle is ignored.
- `cfg_load`+`start` on the same cycle with a valid ratio: new config captured, and the run uses the new values.
- `cnt_completed` outside COUNT: ignored.

## Timing
- `start` sampled at edge N → CLEAR during N+1 → COUNT from N+2.
- `cnt_completed` sampled high at COUNT edge M (not the blank cycle) → `pulse_out` high for cycles M+1 … M+width.
- Back-to-back bursts: COUNT resumes in cycle M+width+1. No CLEAR between bursts; the counter is cleared by the FIRE `cnt_reset`.
- `ctrl_reset` mid-run: next cycle is IDLE with all outputs at reset values; config returns to defaults.
- `abort` and `ctrl_reset` together: `ctrl_reset` wins.
- `abort` during FIRE truncates `pulse_out` the next cycle.

## Test plan
- Reset, then load ratio 15, bursts 3, width 2, and `start`: CLEAR 1 cycle, COUNT; each `cnt_completed` gives a 2-cycle `pulse_out`; `burst_remaining` goes 3→2→1→0; DONE after the third pulse.
- `cnt_completed` held high from before `start`: ignored on the blank cycle; FIRE entered only if still high on the second COUNT cycle.
- Load bursts 0, width 0: continuous 1-cycle pulses; `done` never asserts; `abort` → IDLE with one-cycle `cnt_reset`.
- Load ratio 0: `cfg_error`=1, `cnt_target` stays 15, simultaneous `start` ignored. Then load ratio 8: `cfg_error`=0, `cnt_target`=8.
- `cfg_load`/`start` strobed during COUNT: no effect on registers or state.
- `ctrl_reset` during FIRE: `pulse_out`=0 next cycle, `cnt_target`=1, state IDLE, `burst_remaining`=0.

Source files
------------

// File: rtl/pulse_divider_ctrl.sv
// Sequencing controller for the pulse divider's counter16 datapath: holds the divide
// configuration and runs CLEAR/COUNT/FIRE bursts with registered Moore outputs.
module pulse_divider_ctrl #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PW_WIDTH  = 8
) (
  input  logic                 pulse_clock,
  input  logic                 ctrl_reset,
  input  logic                 cfg_load,
  input  logic [CNT_WIDTH-1:0] cfg_ratio,
  input  logic [CNT_WIDTH-1:0] cfg_bursts,
  input  logic [PW_WIDTH-1:0]  cfg_width,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cnt_completed,
  output logic [CNT_WIDTH-1:0] cnt_target,
  output logic                 cnt_enable,
  output logic                 cnt_reset,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] burst_remaining,
  output logic                 cfg_error
);

  typedef enum logic [2:0] {StIdle, StClear, StCount, StFire, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] ratio_q, ratio_d;
  logic [CNT_WIDTH-1:0] bursts_q, bursts_d;
  logic [PW_WIDTH-1:0]  width_q, width_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [PW_WIDTH-1:0]  pw_cnt_q, pw_cnt_d;
  logic                 blank_q, blank_d;
  logic                 cfg_error_q, cfg_error_d;
  logic                 cnt_enable_q, cnt_enable_d;
  logic                 cnt_reset_q, cnt_reset_d;
  logic                 pulse_out_q, pulse_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_ok;
  logic                 abort_hit;

  assign load_ok = cfg_load && (cfg_ratio != '0);

  always_comb begin
    state_d     = state_q;
    ratio_d     = ratio_q;
    bursts_d    = bursts_q;
    width_d     = width_q;
    remaining_d = remaining_q;
    pw_cnt_d    = pw_cnt_q;
    blank_d     = blank_q;
    cfg_error_d = cfg_error_q;
    abort_hit   = 1'b0;

    if (abort) begin
      state_d     = StIdle;
      remaining_d = '0;
      abort_hit   = 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (cfg_load) begin
            if (load_ok) begin
              ratio_d     = cfg_ratio;
              bursts_d    = cfg_bursts;
              width_d     = cfg_width;
              cfg_error_d = 1'b0;
            end else begin
              cfg_error_d = 1'b1;
            end
          end
          // A rejected load also swallows a start on the same cycle.
          if (start && !(cfg_load && !load_ok)) begin
            state_d     = StClear;
            remaining_d = cfg_load ? cfg_bursts : bursts_q;
          end else if (cfg_load && (state_q == StDone)) begin
            state_d = StIdle;
          end
        end
        StClear: begin
          state_d = StCount;
          blank_d = 1'b1;
        end
        StCount: begin
          blank_d = 1'b0;
          // First COUNT cycle ignores a completion latched before the counter was cleared.
          if (!blank_q && cnt_completed) begin
            state_d  = StFire;
            pw_cnt_d = (width_q == '0) ? '0 : width_q - PW_WIDTH'(1);
            if ((bursts_q != '0) && (remaining_q != '0)) begin
              remaining_d = remaining_q - CNT_WIDTH'(1);
            end
          end
        end
        StFire: begin
          if (pw_cnt_q == '0) begin
            if ((bursts_q == '0) || (remaining_q != '0)) begin
              state_d = StCount;
              blank_d = 1'b1;
            end else begin
              state_d = StDone;
            end
          end else begin
            pw_cnt_d = pw_cnt_q - PW_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are decoded from the next state so the registered copies track state_q.
    busy_d       = (state_d == StClear) || (state_d == StCount) || (state_d == StFire);
    done_d       = (state_d == StDone);
    pulse_out_d  = (state_d == StFire);
    cnt_enable_d = (state_d == StCount);
    cnt_reset_d  = (state_d == StClear) || (state_d == StFire) || abort_hit;
  end

  always_ff @(posedge pulse_clock) begin
    if (ctrl_reset) begin
      state_q      <= StIdle;
      ratio_q      <= CNT_WIDTH'(1);
      bursts_q     <= CNT_WIDTH'(1);
      width_q      <= PW_WIDTH'(1);
      remaining_q  <= '0;
      pw_cnt_q     <= '0;
      blank_q      <= 1'b0;
      cfg_error_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_reset_q  <= 1'b0;
      pulse_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ratio_q      <= ratio_d;
      bursts_q     <= bursts_d;
      width_q      <= width_d;
      remaining_q  <= remaining_d;
      pw_cnt_q     <= pw_cnt_d;
      blank_q      <= blank_d;
      cfg_error_q  <= cfg_error_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_reset_q  <= cnt_reset_d;
      pulse_out_q  <= pulse_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cnt_target      = ratio_q;
  assign cnt_enable      = cnt_enable_q;
  assign cnt_reset       = cnt_reset_q;
  assign pulse_out       = pulse_out_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign burst_remaining = remaining_q;
  assign cfg_error       = cfg_error_q;

endmodule
